dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the byte-addressed, little-endian 32-bit data memory.
- Port 0 is the core load/store unit. Port 1 is the testbench/debug loader.
- Accepts one word request at a time and drives the memory's addr/data/MemRead/MemWrite interface for exactly one cycle.
- Returns read data or a write acknowledge with a fixed 3-cycle cadence.

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: two requester ports plus the data-memory side.
// The slave modport is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req0_valid_i;
  logic              req0_ready_o;
  logic              req0_we_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [DATA_W-1:0] req0_wdata_i;
  logic              req0_rvalid_o;
  logic [DATA_W-1:0] req0_rdata_o;
  logic              req0_err_o;

  logic              req1_valid_i;
  logic              req1_ready_o;
  logic              req1_we_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [DATA_W-1:0] req1_wdata_i;
  logic              req1_rvalid_o;
  logic [DATA_W-1:0] req1_rdata_o;
  logic              req1_err_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [DATA_W-1:0] mem_data_i;

  modport slave (
    input  req0_valid_i, req0_we_i, req0_addr_i, req0_wdata_i,
    output req0_ready_o, req0_rvalid_o, req0_rdata_o, req0_err_o,
    input  req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i,
    output req1_ready_o, req1_rvalid_o, req1_rdata_o, req1_err_o,
    output mem_addr_o, mem_data_o, mem_read_o, mem_write_o,
    input  mem_data_i
  );

  modport master (
    output req0_valid_i, req0_we_i, req0_addr_i, req0_wdata_i,
    input  req0_ready_o, req0_rvalid_o, req0_rdata_o, req0_err_o,
    output req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i,
    input  req1_ready_o, req1_rvalid_o, req1_rdata_o, req1_err_o,
    input  mem_addr_o, mem_data_o, mem_read_o, mem_write_o,
    output mem_data_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter/sequencer: accept -> one-cycle access -> response.
// Optional macro DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round robin.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus
);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              legal_q, legal_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic              last_grant_q, last_grant_d;
`endif

  logic              grant0, grant1;
  logic              sel_we, sel_legal;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    grant0 = bus.req0_valid_i;
`else
    // last_grant_q==1 means port 1 was served last, so port 0 wins a tie
    grant0 = bus.req0_valid_i & (~bus.req1_valid_i | last_grant_q);
`endif
    grant1    = bus.req1_valid_i & ~grant0;
    sel_we    = grant1 ? bus.req1_we_i    : bus.req0_we_i;
    sel_addr  = grant1 ? bus.req1_addr_i  : bus.req0_addr_i;
    sel_wdata = grant1 ? bus.req1_wdata_i : bus.req0_wdata_i;
    sel_legal = (sel_addr[1:0] == 2'b00) && (sel_addr <= MAX_ADDR);
  end

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    we_d         = we_q;
    legal_d      = legal_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          port_d      = grant1;
          we_d        = sel_we;
          legal_d     = sel_legal;
          // memory controls are pre-loaded so they are live for exactly the ACCESS cycle
          mem_addr_d  = sel_legal ? sel_addr  : '0;
          mem_data_d  = sel_legal ? sel_wdata : '0;
          mem_read_d  = sel_legal & ~sel_we;
          mem_write_d = sel_legal & sel_we;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr_d       = '0;
        mem_data_d       = '0;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        rvalid_d         = '0;
        rvalid_d[port_q] = 1'b1;
        rdata_d          = (legal_q && !we_q) ? bus.mem_data_i : '0;
        err_d            = ~legal_q;
        state_d          = RESP;
      end
      RESP: begin
        rvalid_d     = '0;
        rdata_d      = '0;
        err_d        = 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_grant_d = port_q;
`endif
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      legal_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      we_q         <= we_d;
      legal_q      <= legal_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    bus.req0_ready_o  = (state_q == IDLE) & ~rst_i & grant0;
    bus.req1_ready_o  = (state_q == IDLE) & ~rst_i & grant1;
    bus.req0_rvalid_o = rvalid_q[0];
    bus.req1_rvalid_o = rvalid_q[1];
    bus.req0_rdata_o  = rvalid_q[0] ? rdata_q : '0;
    bus.req1_rdata_o  = rvalid_q[1] ? rdata_q : '0;
    bus.req0_err_o    = rvalid_q[0] & err_q;
    bus.req1_err_o    = rvalid_q[1] & err_q;
    bus.mem_addr_o    = mem_addr_q;
    bus.mem_data_o    = mem_data_q;
    bus.mem_read_o    = mem_read_q;
    // a reset landing on the ACCESS cycle must not commit the write
    bus.mem_write_o   = mem_write_q & ~rst_i;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: word-level memory model and transaction-level reference.
module tb_dmem_arbiter;
  localparam int unsigned MEM_BYTES = 128;
  localparam int unsigned WORDS     = MEM_BYTES / 4;

  logic clk;
  logic rst_i;
  int   n_checks = 0;
  int   n_err    = 0;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // environment memory (word storage of the byte-addressed array)
  logic [31:0] tb_mem  [WORDS];
  // reference model state
  logic [31:0] ref_mem [WORDS];
  int          m_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (bus.mem_addr_o < MEM_BYTES) bus.mem_data_i = tb_mem[bus.mem_addr_o >> 2];
    else                            bus.mem_data_i = '0;
  end

  always @(posedge clk) begin
    if (bus.mem_write_o && bus.mem_addr_o < MEM_BYTES)
      tb_mem[bus.mem_addr_o >> 2] <= bus.mem_data_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit v0, input bit v1);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (m_last == 0) ? 1 : 0;
`endif
  endfunction

  function automatic bit is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a <= MEM_BYTES - 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".ready0"}, bus.req0_ready_o, 0);
    chk({tag, ".ready1"}, bus.req1_ready_o, 0);
    chk({tag, ".rvalid0"}, bus.req0_rvalid_o, 0);
    chk({tag, ".rvalid1"}, bus.req1_rvalid_o, 0);
    chk({tag, ".err0"}, bus.req0_err_o, 0);
    chk({tag, ".err1"}, bus.req1_err_o, 0);
    chk({tag, ".rdata0"}, bus.req0_rdata_o, 0);
    chk({tag, ".rdata1"}, bus.req1_rdata_o, 0);
    chk({tag, ".mem_read"}, bus.mem_read_o, 0);
    chk({tag, ".mem_write"}, bus.mem_write_o, 0);
    chk({tag, ".mem_addr"}, bus.mem_addr_o, 0);
    chk({tag, ".mem_data"}, bus.mem_data_o, 0);
  endtask

  // Presents requests in an IDLE cycle, holds them for the full 3-cycle transaction,
  // and checks accept, access and response against the reference.
  task automatic txn(input bit v0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                     input bit v1, input bit we1, input logic [31:0] a1, input logic [31:0] d1,
                     output int won);
    bit          we, legal;
    logic [31:0] a, d, exp_rd;
    bus.req0_valid_i = v0; bus.req0_we_i = we0; bus.req0_addr_i = a0; bus.req0_wdata_i = d0;
    bus.req1_valid_i = v1; bus.req1_we_i = we1; bus.req1_addr_i = a1; bus.req1_wdata_i = d1;
    #1;
    won    = pick(v0, v1);
    we     = (won == 0) ? we0 : we1;
    a      = (won == 0) ? a0  : a1;
    d      = (won == 0) ? d0  : d1;
    legal  = is_legal(a);
    exp_rd = (legal && !we) ? ref_mem[a >> 2] : 32'h0;
    chk("accept.ready0", bus.req0_ready_o, won == 0);
    chk("accept.ready1", bus.req1_ready_o, won == 1);
    chk("accept.rvalid0", bus.req0_rvalid_o, 0);
    chk("accept.rvalid1", bus.req1_rvalid_o, 0);
    chk("accept.mem_read", bus.mem_read_o, 0);
    chk("accept.mem_write", bus.mem_write_o, 0);
    tick();
    chk("access.ready0", bus.req0_ready_o, 0);
    chk("access.ready1", bus.req1_ready_o, 0);
    chk("access.mem_read", bus.mem_read_o, legal && !we);
    chk("access.mem_write", bus.mem_write_o, legal && we);
    chk("access.mem_addr", bus.mem_addr_o, legal ? a : 32'h0);
    chk("access.mem_data", bus.mem_data_o, legal ? d : 32'h0);
    chk("access.rvalid0", bus.req0_rvalid_o, 0);
    chk("access.rvalid1", bus.req1_rvalid_o, 0);
    tick();
    chk("resp.ready0", bus.req0_ready_o, 0);
    chk("resp.ready1", bus.req1_ready_o, 0);
    chk("resp.rvalid0", bus.req0_rvalid_o, won == 0);
    chk("resp.rvalid1", bus.req1_rvalid_o, won == 1);
    chk("resp.rdata0", bus.req0_rdata_o, (won == 0) ? exp_rd : 32'h0);
    chk("resp.rdata1", bus.req1_rdata_o, (won == 1) ? exp_rd : 32'h0);
    chk("resp.err0", bus.req0_err_o, (won == 0) && !legal);
    chk("resp.err1", bus.req1_err_o, (won == 1) && !legal);
    chk("resp.mem_read", bus.mem_read_o, 0);
    chk("resp.mem_write", bus.mem_write_o, 0);
    if (legal && we) ref_mem[a >> 2] = d;
    m_last = won;
    tick();
  endtask

  task automatic clear_inputs();
    bus.req0_valid_i = 0; bus.req0_we_i = 0; bus.req0_addr_i = '0; bus.req0_wdata_i = '0;
    bus.req1_valid_i = 0; bus.req1_we_i = 0; bus.req1_addr_i = '0; bus.req1_wdata_i = '0;
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < WORDS; i++)
      chk(tag, tb_mem[i], ref_mem[i]);
  endtask

  initial begin
    int          w;
    int          start;
    bit          v0, v1, we0, we1;
    logic [31:0] a0, a1, d0, d1;

    for (int i = 0; i < WORDS; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    m_last = 1;
    clear_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst_i = 1'b0;

    // simultaneous reads right after reset: port 0 first, port 1 three cycles later
    txn(1, 0, 32'h04, $urandom, 1, 0, 32'h08, $urandom, w);
    chk("tie_after_reset", w, 0);
    txn(0, 0, 32'h0, 32'h0, 1, 0, 32'h08, $urandom, w);
    chk("second_grant", w, 1);

    // write then read back from the other port
    txn(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, w);
    txn(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0, w);
    chk("mem_0x10", tb_mem[4], 32'hDEADBEEF);

    // both ports held valid continuously for 6 requests
    start = m_last;
    for (int i = 0; i < 6; i++) begin
      a0 = 4 * $urandom_range(0, WORDS - 1);
      a1 = 4 * $urandom_range(0, WORDS - 1);
      txn(1, $urandom_range(0, 1), a0, $urandom, 1, $urandom_range(0, 1), a1, $urandom, w);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      chk("alt_grant", w, 0);
`else
      chk("alt_grant", w, (start + 1 + i) % 2);
`endif
    end

    // illegal writes: misaligned and out of range
    clear_inputs();
    txn(0, 0, 32'h0, 32'h0, 1, 1, 32'h7E, 32'h12345678, w);
    txn(0, 0, 32'h0, 32'h0, 1, 1, 32'h80, 32'h87654321, w);
    chk_mem("mem_after_illegal");

    // reset asserted during the ACCESS cycle of a write
    bus.req0_valid_i = 1; bus.req0_we_i = 1; bus.req0_addr_i = 32'h20; bus.req0_wdata_i = 32'hA5A5A5A5;
    #1;
    chk("rst_acc.ready0", bus.req0_ready_o, 1);
    tick();
    rst_i = 1'b1;
    bus.req0_valid_i = 0;
    #1;
    chk("rst_acc.mem_write", bus.mem_write_o, 0);
    tick();
    bus.req0_valid_i = 1;
    bus.req1_valid_i = 1;
    #1;
    chk_quiet("in_reset");
    tick();
    rst_i = 1'b0;
    clear_inputs();
    #1;
    chk_quiet("after_reset");
    m_last = 1;
    tick();
    chk("mem_0x20", tb_mem[8], ref_mem[8]);
    txn(1, 0, 32'h20, 32'h0, 1, 0, 32'h24, 32'h0, w);
    chk("tie_after_mid_reset", w, 0);

    // idle for 10 cycles
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk_quiet("idle");
      tick();
    end

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      v0  = $urandom_range(0, 1);
      v1  = v0 ? $urandom_range(0, 1) : 1'b1;
      we0 = $urandom_range(0, 1);
      we1 = $urandom_range(0, 1);
      a0  = ($urandom_range(0, 3) != 0) ? 4 * $urandom_range(0, WORDS - 1) : $urandom_range(0, 255);
      a1  = ($urandom_range(0, 3) != 0) ? 4 * $urandom_range(0, WORDS - 1) : $urandom_range(0, 255);
      d0  = $urandom;
      d1  = $urandom;
      txn(v0, we0, a0, d0, v1, we1, a1, d1, w);
    end
    clear_inputs();
    chk_mem("mem_final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
